// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and constants for the AXI4-Stream packet arbiter.
package axis_pkt_arb_pkg;

  // Width of the completed-packet status counter.
  localparam int STS_WIDTH = 32;

  // Arbiter FSM: IDLE arbitrates, BUSY streams one packet from the granted port.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Stream bundle around the arbiter: NUM_PORTS flat slave lanes in, one packet stream out.
// The master modport is the arbiter's view (it masters the output stream);
// the slave modport is the surrounding fabric's view.
interface axis_packet_arbiter_if #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int NUM_PORTS        = 4,
  parameter int SEL_WIDTH        = 2
);

  logic [NUM_PORTS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]                  s_axis_tvalid;
  logic [NUM_PORTS-1:0]                  s_axis_tready;

  logic [AXIS_TDATA_WIDTH-1:0]           m_axis_tdata;
  logic                                  m_axis_tvalid;
  logic                                  m_axis_tready;
  logic                                  m_axis_tlast;
  logic [SEL_WIDTH-1:0]                  m_axis_tuser;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

endinterface

// File: rtl/axis_packet_arbiter_rr_priority_select.sv
// Round-robin pick: first set req bit searching upward from last+1, wrapping at N.
// Rotate the request vector so last+1 sits at bit 0, take the lowest set bit,
// then rotate the index back.
module rr_priority_select
  import axis_pkt_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] last,
  output logic [SEL_WIDTH-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int IW = $clog2(N);

  logic [N-1:0] req_rot;

  // Rotate, priority-encode lowest set bit, map back to a port index.
  always_comb begin
    int start;
    start   = (int'(last) + 1) % N;
    req_rot = '0;
    for (int k = 0; k < N; k++) begin
      req_rot[k] = req[IW'((start + k) % N)];
    end
    gnt_any = |req;
    gnt_idx = '0;
    // Walk downward so the smallest rotated offset wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) gnt_idx = SEL_WIDTH'((start + k) % N);
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: shares one AXI4-Stream output among
// NUM_PORTS free-running sources, one packet of cfg_data+1 beats per grant.
// Datapath is pass-through; only grant, length and beat count are registered.
module axis_packet_arbiter
  import axis_pkt_arb_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32,
  parameter int NUM_PORTS        = 4,
  parameter int SEL_WIDTH        = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  input  logic [NUM_PORTS-1:0]  cfg_mask,
  axis_packet_arbiter_if.master axis,
  output logic [STS_WIDTH-1:0]  sts_packets
);

  state_t                state, state_nxt;
  logic [SEL_WIDTH-1:0]  sel, sel_nxt;
  logic [SEL_WIDTH-1:0]  last_sel, last_nxt;
  logic [CNTR_WIDTH-1:0] cntr, cntr_nxt;
  logic [CNTR_WIDTH-1:0] len_reg, len_nxt;
  logic [STS_WIDTH-1:0]  sts_nxt;

  logic [NUM_PORTS-1:0]  req;
  logic [SEL_WIDTH-1:0]  gnt_idx;
  logic                  gnt_any;

  logic [NUM_PORTS-1:0][AXIS_TDATA_WIDTH-1:0] s_data;
  logic [NUM_PORTS-1:0]  sel_oh;
  logic [AXIS_TDATA_WIDTH-1:0] sel_data;
  logic                  sel_vld;

  logic [AXIS_TDATA_WIDTH-1:0] m_data;
  logic                  m_vld;
  logic                  m_last;
  logic [SEL_WIDTH-1:0]  m_user;
  logic [NUM_PORTS-1:0]  s_rdy;

  assign s_data = axis.s_axis_tdata;
  assign req    = cfg_mask & axis.s_axis_tvalid;

  rr_priority_select #(
    .N         (NUM_PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr (
    .req     (req),
    .last    (last_sel),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // One-hot decode of the granted lane.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    assign sel_oh[g] = (sel == SEL_WIDTH'(g));
  end

  // Granted lane's data/valid, AND-OR mux over the one-hot select.
  always_comb begin
    sel_data = '0;
    sel_vld  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_oh[i]) begin
        sel_data = sel_data | s_data[i];
        sel_vld  = sel_vld  | axis.s_axis_tvalid[i];
      end
    end
  end

  // Next-state and output decode; IDLE keeps every output at zero.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    last_nxt  = last_sel;
    cntr_nxt  = cntr;
    len_nxt   = len_reg;
    sts_nxt   = sts_packets;
    m_data    = '0;
    m_vld     = 1'b0;
    m_last    = 1'b0;
    m_user    = '0;
    s_rdy     = '0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          state_nxt = BUSY;
          sel_nxt   = gnt_idx;
          len_nxt   = cfg_data;
          cntr_nxt  = '0;
        end
      end
      BUSY: begin
        m_data = sel_data;
        m_vld  = sel_vld;
        m_user = sel;
        m_last = (cntr == len_reg);
        s_rdy  = sel_oh & {NUM_PORTS{axis.m_axis_tready}};
        if (m_vld && axis.m_axis_tready) begin
          if (m_last) begin
            // Packet done: rotate priority past this port and take the bubble.
            state_nxt = IDLE;
            last_nxt  = sel;
            sts_nxt   = sts_packets + STS_WIDTH'(1);
          end else begin
            cntr_nxt  = cntr + CNTR_WIDTH'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and bookkeeping registers; reset leaves port 0 with first priority.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      sel         <= '0;
      last_sel    <= SEL_WIDTH'(NUM_PORTS - 1);
      cntr        <= '0;
      len_reg     <= '0;
      sts_packets <= '0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      last_sel    <= last_nxt;
      cntr        <= cntr_nxt;
      len_reg     <= len_nxt;
      sts_packets <= sts_nxt;
    end
  end

  assign axis.m_axis_tdata  = m_data;
  assign axis.m_axis_tvalid = m_vld;
  assign axis.m_axis_tlast  = m_last;
  assign axis.m_axis_tuser  = m_user;
  assign axis.s_axis_tready = s_rdy;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: sources emit {port, seq} beats,
// expected packets are queued per test and popped on each output transfer.
module tb_axis_packet_arbiter;

  localparam int W  = 32;
  localparam int CW = 32;
  localparam int NP = 4;
  localparam int SW = 2;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] user;
    logic          last;
  } beat_t;

  logic          aclk;
  logic          aresetn;
  logic [CW-1:0] cfg_data;
  logic [NP-1:0] cfg_mask;
  logic [31:0]   sts_packets;

  axis_packet_arbiter_if #(.AXIS_TDATA_WIDTH(W), .NUM_PORTS(NP), .SEL_WIDTH(SW)) bus ();

  axis_packet_arbiter #(
    .AXIS_TDATA_WIDTH (W),
    .CNTR_WIDTH       (CW),
    .NUM_PORTS        (NP),
    .SEL_WIDTH        (SW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cfg_data    (cfg_data),
    .cfg_mask    (cfg_mask),
    .axis        (bus),
    .sts_packets (sts_packets)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  beat_t         exp_q[$];
  int            src_seq[NP];
  int            exp_seq[NP];
  logic [NP-1:0] src_en;
  logic [NP-1:0] drop;
  logic [NP-1:0] rdy_seen;
  logic          rnd_rdy;
  logic          gap_chk;
  logic          pkt_first;
  int            last_t;
  int            beats;
  int            cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) bus.s_axis_tdata[p*W +: W] = {8'(p), 24'(src_seq[p])};
    bus.s_axis_tvalid = src_en & ~drop;
    bus.m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_pkt(input int p, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {8'(p), 24'(exp_seq[p])};
      b.user = SW'(p);
      b.last = (i == len - 1);
      exp_q.push_back(b);
      exp_seq[p]++;
    end
  endtask

  task automatic begin_test(input logic gap);
    gap_chk   = gap;
    pkt_first = 1'b1;
    last_t    = -1;
    beats     = 0;
    rdy_seen  = '0;
  endtask

  // One clock: check outputs at negedge, advance sources after posedge.
  task automatic step();
    logic [NP-1:0] hs;
    logic          xfer;
    beat_t         e;
    @(negedge aclk);
    hs   = bus.s_axis_tready & bus.s_axis_tvalid;
    xfer = bus.m_axis_tvalid & bus.m_axis_tready;
    rdy_seen = rdy_seen | bus.s_axis_tready;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("extra_beat", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", bus.m_axis_tdata, e.data);
        chk("tuser", bus.m_axis_tuser, e.user);
        chk("tlast", bus.m_axis_tlast, e.last);
        chk("src_port", hs, NP'(1) << bus.m_axis_tuser);
        if (gap_chk && pkt_first && last_t >= 0) chk("bubble", cyc - last_t, 2);
        pkt_first = bus.m_axis_tlast;
        if (bus.m_axis_tlast) last_t = cyc;
        beats++;
      end
    end else if (hs != '0) begin
      chk("stray_hs", hs, 0);
    end
    @(posedge aclk);
    #1;
    for (int p = 0; p < NP; p++) if (hs[p]) src_seq[p]++;
    drive();
    cyc++;
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, exp_q.size(), 0);
    src_en = '0;
    drive();
  endtask

  task automatic wait_beats(input int k, input int budget);
    int n;
    n = 0;
    while (beats < k && n < budget) begin
      step();
      n++;
    end
    chk("wait_beats", (beats >= k), 1);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      src_seq[p] = 0;
      exp_seq[p] = 0;
    end
    aresetn  = 1'b0;
    cfg_data = CW'(3);
    cfg_mask = 4'hF;
    src_en   = '0;
    drop     = '0;
    rnd_rdy  = 1'b0;
    begin_test(1'b0);
    drive();
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_tlast",  bus.m_axis_tlast, 0);
    chk("rst_tdata",  bus.m_axis_tdata, 0);
    chk("rst_tuser",  bus.m_axis_tuser, 0);
    chk("rst_sready", bus.s_axis_tready, 0);
    chk("rst_sts",    sts_packets, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // All ports valid, 4-beat packets: round robin from port 0.
    begin_test(1'b1);
    for (int k = 0; k < 5; k++) push_pkt(k % NP, 4);
    src_en = 4'hF;
    drive();
    run_until_empty("t1", 200);
    chk("t1_sts", sts_packets, 5);

    // Only port 2 valid, single-beat packets.
    begin_test(1'b1);
    cfg_data = CW'(0);
    for (int k = 0; k < 4; k++) push_pkt(2, 1);
    src_en = 4'b0100;
    drive();
    run_until_empty("t2", 100);
    chk("t2_sts", sts_packets, 9);

    // Mask 0x5: grants alternate 0,2; ports 1 and 3 never see ready.
    begin_test(1'b1);
    cfg_data = CW'(1);
    cfg_mask = 4'h5;
    push_pkt(0, 2); push_pkt(2, 2); push_pkt(0, 2); push_pkt(2, 2);
    src_en = 4'hF;
    drive();
    run_until_empty("t3", 100);
    chk("t3_rdy13", rdy_seen & 4'b1010, 0);
    chk("t3_sts", sts_packets, 13);

    // cfg_data 7 -> 1 mid-packet: current packet stays 8 beats, next is 2.
    begin_test(1'b0);
    cfg_mask = 4'hF;
    cfg_data = CW'(7);
    push_pkt(1, 8); push_pkt(1, 2);
    src_en = 4'b0010;
    drive();
    wait_beats(3, 50);
    cfg_data = CW'(1);
    run_until_empty("t4", 100);
    chk("t4_sts", sts_packets, 15);

    // Random output backpressure plus a 5-cycle valid drop on the granted port.
    begin_test(1'b0);
    cfg_data = CW'(5);
    rnd_rdy  = 1'b1;
    push_pkt(2, 6); push_pkt(3, 6); push_pkt(0, 6); push_pkt(1, 6);
    src_en = 4'hF;
    drive();
    wait_beats(3, 100);
    drop = 4'b0100;
    drive();
    #1;
    chk("t5_drop_vld", bus.m_axis_tvalid, 0);
    repeat (5) step();
    drop = '0;
    drive();
    run_until_empty("t5", 500);
    rnd_rdy = 1'b0;
    drive();
    chk("t5_sts", sts_packets, 19);

    // Reset mid-packet on port 1: outputs clear at once, port 0 wins afterwards.
    begin_test(1'b0);
    cfg_data = CW'(7);
    push_pkt(1, 8);
    src_en = 4'b0010;
    drive();
    wait_beats(3, 50);
    src_en = 4'b0011;
    drive();
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_tvalid", bus.m_axis_tvalid, 0);
    chk("t6_tlast",  bus.m_axis_tlast, 0);
    chk("t6_tdata",  bus.m_axis_tdata, 0);
    chk("t6_tuser",  bus.m_axis_tuser, 0);
    chk("t6_sready", bus.s_axis_tready, 0);
    chk("t6_sts",    sts_packets, 0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    exp_q.delete();
    for (int p = 0; p < NP; p++) exp_seq[p] = src_seq[p];
    begin_test(1'b0);
    push_pkt(0, 8); push_pkt(1, 8);
    run_until_empty("t6", 100);
    chk("t6_sts_end", sts_packets, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
